// File: rtl/balanca_pkg.sv
// Shared constants and types for the scale datapath: price width, display
// digit counts and the converter state encoding.
package balanca_pkg;

  localparam int PRECO_W         = 19;
  localparam int BCD_DIGITS      = 6;
  localparam int MIN_DISP_DIGITS = 3;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } conv_state_t;

  // 10^n as a 64-bit value, used to prove the BCD field can hold any input
  function automatic longint unsigned pow10(input int n);
    longint unsigned r;
    r = 64'd1;
    for (int i = 0; i < n; i++) begin
      r = r * 64'd10;
    end
    return r;
  endfunction

endpackage

// File: rtl/bcd_adj3.sv
// Double-dabble nibble correction: a digit of 5 or more gets +3 so that the
// following left shift carries correctly into the next decimal digit.
module bcd_adj3 (
  input  logic [3:0] din,
  output logic [3:0] dout
);

  // add 3 when the digit would reach 10 or more after doubling
  always_comb begin
    dout = (din >= 4'd5) ? din + 4'd3 : din;
  end

endmodule

// File: rtl/preco_bcd_conv.sv
// Iterative binary-to-BCD converter for the final price (in cents).
// One input bit is consumed per clock; the result and a leading-zero
// blanking mask are registered together and announced with a done pulse.
module preco_bcd_conv
  import balanca_pkg::*;
#(
  parameter int IN_W       = PRECO_W,
  parameter int DIGITS     = BCD_DIGITS,
  parameter int MIN_DIGITS = MIN_DISP_DIGITS
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [IN_W-1:0]     precof,
  output logic                busy,
  output logic                done,
  output logic [4*DIGITS-1:0] bcd,
  output logic [DIGITS-1:0]   digit_en
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(IN_W + 1);
  localparam logic [DIGITS-1:0] EN_RESET = DIGITS'((1 << MIN_DIGITS) - 1);

  // The BCD field must hold the largest input, otherwise the top digit overflows
  if (pow10(DIGITS) <= ((64'd1 << IN_W) - 64'd1)) begin : g_width_check
    $error("preco_bcd_conv: DIGITS too small for IN_W");
  end

  conv_state_t        state;
  conv_state_t        next_state;
  logic [IN_W-1:0]    shreg;
  logic [BCD_W-1:0]   scratch;
  logic [CNT_W-1:0]   cnt;
  logic [BCD_W-1:0]   adj;
  logic [BCD_W-1:0]   scratch_next;
  logic [DIGITS-1:0]  mask;
  logic               load;
  logic               last_iter;
  logic               overflow_unused;

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_adj3 u_adj (
      .din  (scratch[4*g +: 4]),
      .dout (adj[4*g +: 4])
    );
  end

  // The top bit of the adjusted field can never be set because of the width check
  assign overflow_unused = adj[BCD_W-1];
  assign scratch_next    = {adj[BCD_W-2:0], shreg[IN_W-1]};
  assign busy            = (state == SHIFT);

  // Blanking mask: a digit shows if it is one of the fixed low digits or any
  // digit at or above it is nonzero
  always_comb begin
    logic any_nz;
    any_nz = 1'b0;
    mask   = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      any_nz  = any_nz | (scratch_next[4*i +: 4] != 4'd0);
      mask[i] = any_nz | (i < MIN_DIGITS);
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic and the load / finish strobes for the datapath
  always_comb begin
    next_state = state;
    load       = 1'b0;
    last_iter  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load       = 1'b1;
          next_state = SHIFT;
        end
      end
      SHIFT: begin
        if (cnt == CNT_W'(1)) begin
          last_iter  = 1'b1;
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Datapath: capture on start, add-3/shift each iteration, publish on the last
  always_ff @(posedge clk) begin
    if (rst) begin
      shreg    <= '0;
      scratch  <= '0;
      cnt      <= '0;
      bcd      <= '0;
      digit_en <= EN_RESET;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (load) begin
        shreg   <= precof;
        scratch <= '0;
        cnt     <= CNT_W'(IN_W);
      end else if (state == SHIFT) begin
        shreg   <= {shreg[IN_W-2:0], 1'b0};
        scratch <= scratch_next;
        cnt     <= cnt - CNT_W'(1);
        if (last_iter) begin
          bcd      <= scratch_next;
          digit_en <= mask;
          done     <= 1'b1;
        end
      end
    end
  end

endmodule
